mem_responder: RTL

- Memory-side responder for the CPU data path's memory interface. The CPU issues mem_read/mem_write with a 13-bit address and 8-bit write data.
- Holds an 8192 x 8 byte array, inserts a programmable number of wait states, and completes each access with a mem_ready handshake.
- Replaces the zero-latency combinational memory model so the multicycle controller can be exercised against realistic memory timing.

---
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_responder.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Memory request/response bus between the CPU data path and mem_responder.
// Build option: MEM_ERR_EN adds the mem_err response line.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  mem_ready;
`ifdef MEM_ERR_EN
  logic                  mem_err;
`endif

  // CPU side: issues requests, consumes responses
  modport master (
    output address, write_data, mem_read, mem_write,
`ifdef MEM_ERR_EN
    input  mem_err,
`endif
    input  read_data, mem_ready
  );

  // Memory side: consumes requests, drives responses
  modport slave (
    input  address, write_data, mem_read, mem_write,
`ifdef MEM_ERR_EN
    output mem_err,
`endif
    output read_data, mem_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-wide memory responder with programmable wait states and a
// request/ready handshake. Build option: MEM_ERR_EN flags requests that
// assert mem_read and mem_write together instead of treating them as writes.
module mem_responder #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  is_write_r;
  logic [DATA_WIDTH-1:0] read_data_r;
  logic                  mem_ready_r;
  logic                  req_s;
`ifdef MEM_ERR_EN
  logic                  is_err_r;
  logic                  mem_err_r;
`endif

  // Storage array; never cleared by rst
  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];

  assign req_s         = bus.mem_read | bus.mem_write;
  assign bus.read_data = read_data_r;
  assign bus.mem_ready = mem_ready_r;
`ifdef MEM_ERR_EN
  assign bus.mem_err   = mem_err_r;
`endif

  // Access FSM: capture in IDLE, count wait states in BUSY, commit on the
  // BUSY->RESP edge, then hold ready until both request lines drop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      read_data_r <= {DATA_WIDTH{1'b0}};
      mem_ready_r <= 1'b0;
`ifdef MEM_ERR_EN
      mem_err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            addr_r     <= bus.address;
            wdata_r    <= bus.write_data;
            // Without the error option a dual request proceeds as a write
            is_write_r <= bus.mem_write;
`ifdef MEM_ERR_EN
            is_err_r   <= bus.mem_read & bus.mem_write;
`endif
            cnt_r      <= 4'(WAIT_STATES);
            state_r    <= BUSY;
          end else begin
            state_r    <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
`ifdef MEM_ERR_EN
            if (is_err_r) begin
              mem_err_r <= 1'b1;
            end else if (is_write_r) begin
              mem_r[addr_r] <= wdata_r;
            end else begin
              read_data_r <= mem_r[addr_r];
            end
`else
            if (is_write_r) begin
              mem_r[addr_r] <= wdata_r;
            end else begin
              read_data_r <= mem_r[addr_r];
            end
`endif
            mem_ready_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (!req_s) begin
            mem_ready_r <= 1'b0;
`ifdef MEM_ERR_EN
            mem_err_r   <= 1'b0;
`endif
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          mem_ready_r <= 1'b0;
`ifdef MEM_ERR_EN
          mem_err_r   <= 1'b0;
`endif
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
